// File: rtl/eth_stream_pkg.sv
// Shared definitions for the Ethernet stream path.
// Contents: arbiter FSM state type and the per-channel stream type codes.
package eth_stream_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  localparam int STREAM_TYPE_WIDTH = 3;

  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_AR = 3'd0;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_R  = 3'd1;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_AW = 3'd2;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_W  = 3'd3;
  localparam logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE_B  = 3'd4;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO between the arbiter mux and the outbound stream.
// Ports:
//   clk, resetn  - clock, async active-low reset
//   push_i       - write data_i (caller guarantees not_full_o)
//   data_i       - payload in
//   ready_i      - downstream ready; pop = valid_o & ready_i
//   valid_o      - head entry valid
//   data_o       - head entry payload
//   not_full_o   - registered "space available", safe to drive a ready
module stream_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             not_full_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;
  logic             not_full_q;
  logic             pop;

  assign valid_o    = (count_q != 2'd0);
  assign data_o     = mem_q[rd_ptr_q];
  assign not_full_o = not_full_q;
  assign pop        = valid_o & ready_i;

  always_comb begin
    count_d = count_q;
    case ({push_i, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      not_full_q <= 1'b1;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q    <= count_d;
      // Registered from the next count so the arbiter's ready has no
      // combinational path from the downstream ready.
      not_full_q <= (count_d != 2'd2);
    end
  end

endmodule

// File: rtl/eth_stream_arbiter.sv
// Round-robin arbiter sharing one outbound stream among NUM_SRC channel taps.
// A grant is held for a whole burst (through the beat flagged last) or until
// the idle watchdog revokes a stalled, not-in-progress owner.
// Ports:
//   clk, resetn                 - clock, async active-low reset
//   src_req/valid/in_progress/last/data - per-source request and beat inputs
//   src_ready                   - one-hot ready to the granted source
//   m_axis_tdata/tuser/tlast/tvalid/tready - outbound stream (tuser = source)
//   grant_idx, busy             - current owner and grant-held flag
//
// state     | meaning
// ARB_IDLE  | no owner; pick next requester after rr_ptr
// ARB_GRANT | grant_idx owns the stream until last beat or watchdog
module eth_stream_arbiter
  import eth_stream_pkg::*;
#(
  parameter int NUM_SRC      = 5,
  parameter int DATA_WIDTH   = 128,
  parameter int IDX_WIDTH    = $clog2(NUM_SRC),
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_SRC-1:0]            src_req,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC-1:0]            src_in_progress,
  input  logic [NUM_SRC-1:0]            src_last,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [IDX_WIDTH-1:0]          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [IDX_WIDTH-1:0]          grant_idx,
  output logic                          busy
);

  localparam int PW    = DATA_WIDTH + IDX_WIDTH + 1;
  localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

  arb_state_t           state_q, state_d;
  logic [IDX_WIDTH-1:0] grant_q, grant_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;

  logic [IDX_WIDTH-1:0] rr_sel;
  logic [IDX_WIDTH-1:0] scan_idx;
  logic                 rr_found;
  logic                 buf_not_full;
  logic                 beat;
  logic [PW-1:0]        push_data;
  logic [PW-1:0]        head;

  assign busy      = (state_q == ARB_GRANT);
  assign grant_idx = grant_q;
  assign src_ready = (busy && buf_not_full) ? (NUM_SRC'(1) << grant_q) : '0;
  assign beat      = src_valid[grant_q] & src_ready[grant_q];
  assign push_data = {src_data[grant_q*DATA_WIDTH +: DATA_WIDTH], grant_q, src_last[grant_q]};

  // First requester strictly after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    rr_sel   = '0;
    rr_found = 1'b0;
    scan_idx = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      scan_idx = IDX_WIDTH'((32'(rr_ptr_q) + 32'(i)) % NUM_SRC);
      if (!rr_found && src_req[scan_idx]) begin
        rr_found = 1'b1;
        rr_sel   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (rr_found) begin
          state_d    = ARB_GRANT;
          grant_d    = rr_sel;
          idle_cnt_d = '0;
        end
      end
      ARB_GRANT: begin
        if (beat) begin
          idle_cnt_d = '0;
          if (src_last[grant_q]) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = grant_q;
          end
        end else if (!src_in_progress[grant_q]) begin
          // A source mid-burst is never timed out; only idle owners are.
          if (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
            state_d    = ARB_IDLE;
            rr_ptr_d   = grant_q;
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= IDX_WIDTH'(NUM_SRC - 1);
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  stream_skid_buffer #(.WIDTH(PW)) u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .push_i     (beat),
    .data_i     (push_data),
    .ready_i    (m_axis_tready),
    .valid_o    (m_axis_tvalid),
    .data_o     (head),
    .not_full_o (buf_not_full)
  );

  assign m_axis_tdata = head[PW-1 -: DATA_WIDTH];
  assign m_axis_tuser = head[IDX_WIDTH:1];
  assign m_axis_tlast = head[0];

endmodule

// File: doc/eth_stream_arbiter.md
# eth_stream_arbiter

Round-robin arbiter that shares the single outbound AXI-Stream toward the Ethernet packetizer among `NUM_SRC` AXI-to-stream monitor submodules (AR, R, AW, W, B channel taps). It grants one submodule at a time and holds the grant for the whole burst, from the first metadata beat through the beat flagged `last`. Beats pass through a 2-entry output buffer, so `m_axis_tvalid` never depends combinationally on `m_axis_tready`. The block sits between the per-channel submodules and the stream packetizer.

## Interface

Parameters:
- `NUM_SRC`, 5: number of requesting submodules (2..8).
- `DATA_WIDTH`, 128: stream beat width.
- `IDX_WIDTH`, `$clog2(NUM_SRC)`: width of the source index.
- `IDLE_TIMEOUT`, 16: cycles a granted source may stall before its grant is revoked.

Ports:
- `clk` in 1: the single clock; all logic is on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `src_req` in NUM_SRC: source has pending traffic. This is raw, unmasked, and must not depend on `src_ready`.
- `src_valid` in NUM_SRC: beat strobe. It may depend combinationally on `src_ready`.
- `src_in_progress` in NUM_SRC: source is mid-burst.
- `src_last` in NUM_SRC: current beat is the last beat of the burst.
- `src_data` in NUM_SRC*DATA_WIDTH: beat data, source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `src_ready` out NUM_SRC: one-hot or zero. Asserts only for the granted source.
- `m_axis_tdata` out DATA_WIDTH: outbound beat data.
- `m_axis_tuser` out IDX_WIDTH: index of the source that produced the beat.
- `m_axis_tlast` out 1: outbound last-beat flag.
- `m_axis_tvalid` out 1: outbound beat valid.
- `m_axis_tready` in 1: downstream ready.
- `grant_idx` out IDX_WIDTH: index of the current owner.
- `busy` out 1: high while a grant is held.

## Operation

**Reset and state**
- On reset, all outputs are 0, the state is IDLE, the buffer is empty, and `rr_ptr` = NUM_SRC-1, so source 0 has first priority.

**IDLE**
- `src_ready` = 0.
- If any `src_req` bit is set, select the first requester scanning from `rr_ptr`+1 upward, with modulo NUM_SRC wrap-around.
- Register the selected index into `grant_idx` and go to GRANT. `busy` = 1 from the next cycle.

**GRANT**
- `src_ready[grant_idx]` = `buf_not_full`. This is purely registered and contains no path from `src_valid` or `m_axis_tready`.
- A beat occurs when `src_valid[g]` and `src_ready[g]` are both high. The beat writes `{src_data[g], g, src_last[g]}` into the buffer.
- A beat with `src_last` set ends the burst: go to IDLE and set `rr_ptr` = g.

**Watchdog**
- The idle counter resets to 0 on every beat.
- It increments each cycle with no beat while `src_in_progress[g]` = 0.
- It holds while `src_in_progress[g]` = 1, so a burst is never torn apart.
- When the counter reaches IDLE_TIMEOUT-1, go to IDLE, set `rr_ptr` = g, and emit no beat.

**Output buffer**
- The buffer is a 2-entry FIFO. `m_axis_*` is driven from the head entry.
- Pop occurs on `m_axis_tvalid & m_axis_tready`.
- Push and pop in the same cycle are legal at count 1 or 2; count stays the same.
- Push never occurs at count 2, because `src_ready` is low then.

**Reset mid-operation**
- Asserting reset mid-operation clears the grant and the buffer immediately.
- In-flight beats are dropped, and `m_axis_tvalid` falls asynchronously.

## Timing

- **Request to grant:** request seen in cycle 0 gives `grant_idx`/`busy` valid in cycle 1 and `src_ready` high in cycle 1 if the buffer is not full.
- **Beat to output:** a beat accepted in cycle k appears on `m_axis_tvalid` in cycle k+1.
- **Throughput:** with `m_axis_tready` held high, 1 beat per cycle is sustained.
- **Release to next grant:** a last beat in cycle k gives IDLE in k+1 and the next grant in k+2, a 1-cycle bubble.
- **Backpressure:** `m_axis_tready` low fills the buffer in 2 beats, then `src_ready` drops the following cycle. No beat is lost or duplicated.
- **Simultaneous requests:** resolved by round-robin only; there is no fixed priority after the first grant.
- **Single-beat burst:** `src_last` on the first beat releases after 1 beat.

## Structure

- Shared package `eth_stream_pkg` holds:
  - the `arb_state_t` enum {ARB_IDLE, ARB_GRANT};
  - the STREAM_TYPE codes per channel (AR, R, AW, W, B; 3 bits);
  - `STREAM_TYPE_WIDTH` = 3.
- Sub-module `stream_skid_buffer` implements the 2-entry FIFO. It is parameterized by payload width (DATA_WIDTH+IDX_WIDTH+1) and exposes `not_full` as a registered output.
- The arbiter top holds the FSM, `rr_ptr`, the round-robin select, the watchdog counter, and the input mux.

## Test plan

- **Simultaneous requests:**
  - Stimulus: after reset, `src_req` = 5'b10110.
  - Required: grants in order 1, 2, 4, each for its full burst. Each burst is 3 beats, `last` on beat 3. `m_axis_tuser` = 1, 1, 1, 2, 2, 2, 4, 4, 4, with `tlast` on every third beat.
- **Backpressure:**
  - Stimulus: a source streams 8 beats (data 0..7); `m_axis_tready` is low for cycles 3–7.
  - Required: `src_ready` drops after the buffer holds 2 beats. Output is data 0..7, exactly once and in order, with `tlast` only on data 7.
- **Watchdog revoke:**
  - Stimulus: source 3 is granted and sends 0 beats with `src_in_progress` = 0.
  - Required: after 16 cycles `busy` = 0. The next grant goes to source 4 if it is requesting, else wraps to 0.
- **Watchdog hold:**
  - Stimulus: source 0 has `src_in_progress` = 1 and stalls for 40 cycles.
  - Required: the grant is kept, with no revoke.
- **Reset mid-burst:**
  - Stimulus: assert `resetn` = 0 during beat 2 of 4.
  - Required: `m_axis_tvalid`, `src_ready` and `busy` go to 0 in the same cycle. After release, source 0 is granted first.
